// File: rtl/fie_bram_pkg.sv
// Shared types and helpers for the BRAM bit-flip fault-injection master.
// The optional readback states VRD/VCMP are only reached when FIE_READBACK_VERIFY_EN is defined.
package fie_bram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        VRD,
        VCMP,
        DONE
    } state_t;

    // Word addresses must have their two least-significant byte-address bits clear.
    localparam int ALIGN_BITS = 2;

    // A byte lane is written only if the mask flips at least one of its bits.
    function automatic logic mask_byte_wen(input logic [0:7] mask_byte);
        return |mask_byte;
    endfunction

endpackage

// File: rtl/fie_sat_counter.sv
// Saturating up-counter with a clear that takes priority over increment.
module fie_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fie_bram_bitflip_ctrl.sv
// Read-modify-write bit-flip injector on BRAM port B (port A remains with the LMB controller).
// Define FIE_READBACK_VERIFY_EN to add a readback compare after the write.
module fie_bram_bitflip_ctrl
    import fie_bram_pkg::*;
#(
    parameter int C_MEMSIZE     = 'h8000,
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_NUM_WE      = 4,
    parameter int C_CNT_WIDTH   = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Inj_Valid,
    output logic                     Inj_Ready,
    input  logic [0:C_PORT_AWIDTH-1] Inj_Addr,
    input  logic [0:C_PORT_DWIDTH-1] Inj_Mask,
    output logic                     Inj_Done,
    output logic                     Inj_Err,
    output logic [0:C_PORT_DWIDTH-1] Inj_Old_Data,
    output logic [0:C_PORT_DWIDTH-1] Inj_New_Data,
    output logic [C_CNT_WIDTH-1:0]   Inj_Count,
    input  logic                     Cnt_Clr,
    output logic                     BRAM_Clk,
    output logic                     BRAM_Rst,
    output logic                     BRAM_EN,
    output logic [0:C_NUM_WE-1]      BRAM_WEN,
    output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

    state_t                   state_reg;
    logic [0:C_PORT_DWIDTH-1] mask_reg;
    logic                     success_reg;
    logic [0:C_NUM_WE-1]      wen_vec;
    logic [0:C_PORT_DWIDTH-1] flipped_word;
    logic                     addr_illegal;

    assign BRAM_Clk  = Clk;
    assign BRAM_Rst  = Rst;
    assign Inj_Ready = (state_reg == IDLE);

    assign addr_illegal = (|Inj_Addr[C_PORT_AWIDTH-ALIGN_BITS +: ALIGN_BITS]) ||
                          (Inj_Addr >= C_PORT_AWIDTH'(C_MEMSIZE));
    assign flipped_word = BRAM_Din ^ mask_reg;

    for (genvar gi = 0; gi < C_NUM_WE; gi++) begin : g_wen
        assign wen_vec[gi] = mask_byte_wen(mask_reg[gi*8 +: 8]);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg    <= IDLE;
            mask_reg     <= '0;
            success_reg  <= 1'b0;
            BRAM_EN      <= 1'b0;
            BRAM_WEN     <= '0;
            BRAM_Addr    <= '0;
            BRAM_Dout    <= '0;
            Inj_Done     <= 1'b0;
            Inj_Err      <= 1'b0;
            Inj_Old_Data <= '0;
            Inj_New_Data <= '0;
        end else begin
            // Enables and the done strobe are asserted only for the single cycle that needs them.
            BRAM_EN  <= 1'b0;
            BRAM_WEN <= '0;
            Inj_Done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Inj_Valid) begin
                        mask_reg <= Inj_Mask;
                        if (addr_illegal) begin
                            state_reg   <= DONE;
                            Inj_Done    <= 1'b1;
                            Inj_Err     <= 1'b1;
                            success_reg <= 1'b0;
                        end else begin
                            state_reg <= RD;
                            BRAM_EN   <= 1'b1;
                            BRAM_Addr <= Inj_Addr;
                        end
                    end
                end
                RD: begin
                    state_reg <= CAP;
                end
                CAP: begin
                    Inj_Old_Data <= BRAM_Din;
                    Inj_New_Data <= flipped_word;
                    if (|mask_reg) begin
                        state_reg <= WR;
                        BRAM_EN   <= 1'b1;
                        BRAM_WEN  <= wen_vec;
                        BRAM_Dout <= flipped_word;
                    end else begin
                        // Nothing to flip: finish without a write and without counting.
                        state_reg   <= DONE;
                        Inj_Done    <= 1'b1;
                        Inj_Err     <= 1'b0;
                        success_reg <= 1'b0;
                    end
                end
                WR: begin
`ifdef FIE_READBACK_VERIFY_EN
                    state_reg <= VRD;
                    BRAM_EN   <= 1'b1;
`else
                    state_reg   <= DONE;
                    Inj_Done    <= 1'b1;
                    Inj_Err     <= 1'b0;
                    success_reg <= 1'b1;
`endif
                end
`ifdef FIE_READBACK_VERIFY_EN
                VRD: begin
                    state_reg <= VCMP;
                end
                VCMP: begin
                    state_reg   <= DONE;
                    Inj_Done    <= 1'b1;
                    Inj_Err     <= (BRAM_Din != Inj_New_Data);
                    success_reg <= (BRAM_Din == Inj_New_Data);
                end
`endif
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The count advances at the end of DONE so a clear issued during DONE overrides it.
    fie_sat_counter #(
        .WIDTH (C_CNT_WIDTH)
    ) u_counter (
        .clk   (Clk),
        .srst  (Rst),
        .inc   ((state_reg == DONE) && success_reg),
        .clr   (Cnt_Clr),
        .count (Inj_Count)
    );

endmodule
